// File: rtl/ps2_key_state_tracker_pkg.sv
// Shared PS/2 constants, decoder state encoding and key index assignments
// for the key-state tracker slice.
package ps2_key_state_tracker_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    typedef enum logic [1:0] {
        DEC_IDLE    = 2'd0,
        DEC_BREAK   = 2'd1,
        DEC_EXT     = 2'd2,
        DEC_EXT_BRK = 2'd3
    } decState_t;

    localparam int NUMBEROFKEYBOARDINPUTS = 29;

    // Key indices follow the order of the scan-code table in the tracker.
    localparam int keyBacktick = 0;
    localparam int keyTab      = 14;
    localparam int keyQ        = 15;
    localparam int keyW        = 16;
    localparam int keySpace    = 28;

endpackage

// File: rtl/ps2_key_state_tracker_if.sv
// PS/2 byte input and press/release event output of the key-state tracker.
interface ps2_key_state_tracker_if #(
    parameter int KEY_IDX_W = 5
);
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 evt_valid;
    logic [KEY_IDX_W-1:0] evt_key;
    logic                 evt_press;
    logic                 evt_ready;

    modport master (
        output rx_data, rx_valid, evt_ready,
        input  evt_valid, evt_key, evt_press
    );

    modport slave (
        input  rx_data, rx_valid, evt_ready,
        output evt_valid, evt_key, evt_press
    );
endinterface

// File: rtl/ps2_key_state_tracker_key_event_fifo.sv
// Synchronous show-ahead FIFO for key events; a push while full is accepted
// only when a pop happens in the same cycle.
module key_event_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 8
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr, rdPtr;
    logic             doPush, doPop;

    // Extra pointer bit distinguishes full from empty.
    assign empty   = (wrPtr == rdPtr);
    assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doPop   = pop && !empty;
    assign doPush  = push && (!full || doPop);
    assign popData = mem[rdPtr[AW-1:0]];

    always_ff @(posedge CLOCK_50) begin
        if (resetn) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
            if (doPop)  rdPtr <= rdPtr + (AW+1)'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
    end
endmodule

// File: rtl/ps2_key_state_tracker.sv
// Decodes PS/2 make/break/extended sequences into a held-key vector and a
// queue of press/release events, ignoring typematic repeats.
module ps2_key_state_tracker
    import ps2_key_state_tracker_pkg::*;
#(
    parameter int NUM_KEYS   = NUMBEROFKEYBOARDINPUTS,
    parameter int FIFO_DEPTH = 8,
    parameter int KEY_IDX_W  = $clog2(NUM_KEYS)
) (
    input  logic                          CLOCK_50,
    input  logic                          resetn,
    ps2_key_state_tracker_if.slave        bus,
    output logic [NUM_KEYS-1:0]           key_state,
    output logic [$clog2(NUM_KEYS+1)-1:0] pressed_count,
    output logic                          fifo_overflow,
    output logic                          unknown_code
);
    localparam int CNT_W = $clog2(NUM_KEYS+1);

    function automatic int scanIndex(input logic [7:0] code);
        int k;
        case (code)
            8'h0E: k = 0;   8'h16: k = 1;   8'h1E: k = 2;   8'h26: k = 3;
            8'h25: k = 4;   8'h2E: k = 5;   8'h36: k = 6;   8'h3D: k = 7;
            8'h3E: k = 8;   8'h46: k = 9;   8'h45: k = 10;  8'h4E: k = 11;
            8'h55: k = 12;  8'h66: k = 13;  8'h0D: k = 14;  8'h15: k = 15;
            8'h1D: k = 16;  8'h24: k = 17;  8'h2D: k = 18;  8'h2C: k = 19;
            8'h35: k = 20;  8'h3C: k = 21;  8'h43: k = 22;  8'h44: k = 23;
            8'h4D: k = 24;  8'h54: k = 25;  8'h5B: k = 26;  8'h5D: k = 27;
            8'h29: k = 28;
            default: k = -1;
        endcase
        return k;
    endfunction

    function automatic logic [CNT_W-1:0] popCount(input logic [NUM_KEYS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_KEYS; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    decState_t state, stateNext;
    logic finalMake, finalBreak, pauseCode;
    int   scanK;
    logic hit, keyHeld, doPress, doRelease, push, pop, full, empty;
    logic [KEY_IDX_W-1:0] idx;
    logic [NUM_KEYS-1:0]  keyMask, keyStateNext;
    logic [KEY_IDX_W:0]   popData;

    assign scanK   = scanIndex(bus.rx_data);
    assign hit     = (scanK >= 0) && (scanK < NUM_KEYS);
    assign idx     = KEY_IDX_W'(scanK);
    assign keyMask = hit ? (NUM_KEYS'(1) << idx) : '0;
    assign keyHeld = |(key_state & keyMask);

    always_ff @(posedge CLOCK_50) begin
        if (resetn) state <= DEC_IDLE;
        else        state <= stateNext;
    end

    // Extended final bytes return to idle with no effect: no mapping exists yet.
    always_comb begin
        stateNext  = state;
        finalMake  = 1'b0;
        finalBreak = 1'b0;
        pauseCode  = 1'b0;
        if (bus.rx_valid) begin
            case (state)
                DEC_IDLE: begin
                    if (bus.rx_data == PS2_BREAK)      stateNext = DEC_BREAK;
                    else if (bus.rx_data == PS2_EXT)   stateNext = DEC_EXT;
                    else if (bus.rx_data == PS2_PAUSE) pauseCode = 1'b1;
                    else                               finalMake = 1'b1;
                end
                DEC_BREAK: begin
                    finalBreak = 1'b1;
                    stateNext  = DEC_IDLE;
                end
                DEC_EXT:     stateNext = (bus.rx_data == PS2_BREAK) ? DEC_EXT_BRK : DEC_IDLE;
                DEC_EXT_BRK: stateNext = DEC_IDLE;
                default:     stateNext = DEC_IDLE;
            endcase
        end
    end

    assign doPress      = finalMake && hit && !keyHeld;
    assign doRelease    = finalBreak && hit && keyHeld;
    assign keyStateNext = (key_state | (doPress ? keyMask : '0)) & ~(doRelease ? keyMask : '0);
    assign push         = doPress || doRelease;
    assign pop          = bus.evt_valid && bus.evt_ready;

    always_ff @(posedge CLOCK_50) begin
        if (resetn) begin
            key_state     <= '0;
            pressed_count <= '0;
            fifo_overflow <= 1'b0;
            unknown_code  <= 1'b0;
        end else begin
            key_state     <= keyStateNext;
            pressed_count <= popCount(keyStateNext);
            unknown_code  <= pauseCode || ((finalMake || finalBreak) && !hit);
            if (push && full && !pop) fifo_overflow <= 1'b1;
        end
    end

    key_event_fifo #(
        .WIDTH (KEY_IDX_W+1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .push     (push),
        .pushData ({idx, doPress}),
        .pop      (pop),
        .popData  (popData),
        .full     (full),
        .empty    (empty)
    );

    assign bus.evt_valid = !empty;
    assign bus.evt_key   = popData[KEY_IDX_W:1];
    assign bus.evt_press = popData[0];
endmodule

// File: tb/tb_ps2_key_state_tracker.sv
// Scoreboard bench for ps2_key_state_tracker: a held-key/prefix-flag model
// predicts outputs and events; a monitor pops events as the DUT presents them.
module tb_ps2_key_state_tracker;
    localparam int NK = 29, DEPTH = 8, IW = 5, CW = 5;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    ps2_key_state_tracker_if #(.KEY_IDX_W(IW)) bus();
    logic [NK-1:0] key_state;
    logic [CW-1:0] pressed_count;
    logic          fifo_overflow, unknown_code;

    ps2_key_state_tracker #(.NUM_KEYS(NK), .FIFO_DEPTH(DEPTH), .KEY_IDX_W(IW)) dut (
        .CLOCK_50      (clk),
        .resetn        (resetn),
        .bus           (bus),
        .key_state     (key_state),
        .pressed_count (pressed_count),
        .fifo_overflow (fifo_overflow),
        .unknown_code  (unknown_code)
    );

    logic [7:0] codes [NK] = '{8'h0E, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                               8'h3E, 8'h46, 8'h45, 8'h4E, 8'h55, 8'h66, 8'h0D, 8'h15,
                               8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44,
                               8'h4D, 8'h54, 8'h5B, 8'h5D, 8'h29};

    typedef struct { int key; bit press; } evt_t;
    evt_t expQ[$];
    bit   held [NK];
    bit   brk, ext, expUnk, expOvf, started;
    int   errors = 0, checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lookupCode(input logic [7:0] b);
        for (int i = 0; i < NK; i++) if (codes[i] == b) return i;
        return -1;
    endfunction

    function automatic logic [31:0] heldVec();
        logic [31:0] v = '0;
        for (int i = 0; i < NK; i++) v[i] = held[i];
        return v;
    endfunction

    function automatic int heldCount();
        int c = 0;
        for (int i = 0; i < NK; i++) c += int'(held[i]);
        return c;
    endfunction

    task automatic pushExp(input int k, input bit press);
        evt_t e;
        e.key = k;
        e.press = press;
        if (expQ.size() < DEPTH) expQ.push_back(e);
        else expOvf = 1'b1;
    endtask

    // Prefix flags: a byte after F0 is always final; E0/E1 only matter before any prefix.
    task automatic modelByte(input logic [7:0] b);
        bit fin = 1'b0;
        int k;
        if (brk)                          fin = 1'b1;
        else if (b == 8'hF0)              brk = 1'b1;
        else if (!ext && b == 8'hE0)      ext = 1'b1;
        else if (!ext && b == 8'hE1)      expUnk = 1'b1;
        else                              fin = 1'b1;
        if (fin) begin
            if (!ext) begin
                k = lookupCode(b);
                if (k < 0) expUnk = 1'b1;
                else if (!brk && !held[k]) begin held[k] = 1'b1; pushExp(k, 1'b1); end
                else if (brk && held[k])   begin held[k] = 1'b0; pushExp(k, 1'b0); end
            end
            brk = 1'b0;
            ext = 1'b0;
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NK; i++) held[i] = 1'b0;
        expQ.delete();
        brk = 1'b0; ext = 1'b0; expUnk = 1'b0; expOvf = 1'b0;
    endtask

    task automatic checkOutputs();
        check("key_state", 32'(key_state), heldVec());
        check("pressed_count", 32'(pressed_count), 32'(heldCount()));
        check("unknown_code", 32'(unknown_code), 32'(expUnk));
        check("fifo_overflow", 32'(fifo_overflow), 32'(expOvf));
    endtask

    task automatic step(input bit v, input logic [7:0] b, input bit rdy);
        @(negedge clk);
        if (started) checkOutputs();
        bus.rx_valid  = v;
        bus.rx_data   = b;
        bus.evt_ready = rdy;
        #2;
        expUnk = 1'b0;
        if (v) modelByte(b);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy);
    endtask

    task automatic doReset();
        @(negedge clk);
        if (started) checkOutputs();
        bus.rx_valid  = 1'b0;
        bus.evt_ready = 1'b0;
        resetn = 1'b1;
        #2;
        modelReset();
        @(negedge clk);
        resetn = 1'b0;
        started = 1'b1;
        check("reset key_state", 32'(key_state), 32'd0);
        check("reset pressed_count", 32'(pressed_count), 32'd0);
        check("reset evt_valid", 32'(bus.evt_valid), 32'd0);
    endtask

    // Monitor: the DUT pops on the coming edge whenever valid and ready are both high.
    always @(negedge clk) begin
        evt_t e;
        #1;
        if (started) begin
            check("evt_valid", 32'(bus.evt_valid), 32'(expQ.size() != 0));
            if (bus.evt_valid && bus.evt_ready && expQ.size() > 0) begin
                e = expQ.pop_front();
                check("evt_key", 32'(bus.evt_key), 32'(e.key));
                check("evt_press", 32'(bus.evt_press), 32'(e.press));
            end
        end
    end

    initial begin
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.evt_ready = 1'b0;
        started = 1'b0;
        modelReset();
        doReset();

        // press, typematic repeats, second key, break of first only
        step(1'b1, 8'h15, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h15, 1'b1);
        step(1'b1, 8'h1D, 1'b1);
        step(1'b1, 8'hF0, 1'b1);
        step(1'b1, 8'h15, 1'b1);
        idle(2, 1'b1);

        // extended sequences are consumed silently; spacebar then decodes normally
        step(1'b1, 8'hE0, 1'b1); step(1'b1, 8'h75, 1'b1);
        step(1'b1, 8'hE0, 1'b1); step(1'b1, 8'hF0, 1'b1); step(1'b1, 8'h75, 1'b1);
        step(1'b1, 8'h29, 1'b1);
        step(1'b1, 8'h7E, 1'b1);
        step(1'b1, 8'hE1, 1'b1);
        step(1'b1, 8'h16, 1'b1);
        idle(2, 1'b1);

        // overflow: nine presses into an eight-entry queue with no consumer
        doReset();
        for (int i = 0; i < 9; i++) step(1'b1, codes[i], 1'b0);
        idle(2, 1'b0);
        idle(10, 1'b1);

        // full queue with simultaneous push and pop
        doReset();
        for (int i = 0; i < 8; i++) step(1'b1, codes[i], 1'b0);
        step(1'b1, codes[8], 1'b1);
        idle(2, 1'b0);
        idle(10, 1'b1);

        // reset between F0 and 15
        step(1'b1, 8'hF0, 1'b0);
        doReset();
        step(1'b1, 8'h15, 1'b1);
        idle(2, 1'b1);

        // randomized traffic, back-to-back strobes and random consumer stalls
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [7:0] b;
            r = int'($urandom_range(0, 9));
            if (r <= 5)      b = codes[$urandom_range(0, NK-1)];
            else if (r == 6) b = 8'hF0;
            else if (r == 7) b = 8'hE0;
            else if (r == 8) b = 8'hE1;
            else             b = 8'($urandom);
            step(1'($urandom_range(0, 3) != 0), b, 1'($urandom_range(0, 9) < 6));
        end
        idle(12, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
